// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNT_W = 6;

    function automatic logic [DEFAULT_WIDTH-1:0] cond_negate(
        input logic [DEFAULT_WIDTH-1:0] value,
        input logic                     negate
    );
        return negate ? (~value + DEFAULT_WIDTH'(1)) : value;
    endfunction

endpackage

// File: rtl/seq_divider_div_sign_fix.sv
// Conditional two's-complement negation: operand magnitude or signed result correction.
module div_sign_fix
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    generate
        if (WIDTH == DEFAULT_WIDTH) begin : g_pkg
            assign result = cond_negate(value, negate);
        end else begin : g_generic
            assign result = negate ? (~value + WIDTH'(1)) : value;
        end
    endgenerate

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU; one quotient bit per BUSY cycle.
// Optional early-out for trivial operands under SEQ_DIVIDER_EARLY_OUT_EN.
//
//   state | meaning
//   IDLE  | waiting for div_begin; operands sampled on the start edge
//   BUSY  | one shift/trial-subtract per cycle; div_begin low aborts
//   DONE  | div_end high for this single cycle, results valid
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_begin,
    input  logic             div_sign,
    input  logic [WIDTH-1:0] div_op1,
    input  logic [WIDTH-1:0] div_op2,
    output logic [WIDTH-1:0] div_result,
    output logic [WIDTH-1:0] div_remainder,
    output logic             div_end
);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem, quo, dvs;
    logic             q_neg, r_neg, skip, early;
    logic [WIDTH-1:0] op1_mag, op2_mag;
    logic [WIDTH:0]   rem_wide, diff;
    logic [WIDTH-1:0] rem_next, quo_next, q_fixed, r_fixed;

    div_sign_fix #(.WIDTH(WIDTH)) u_abs_op1 (
        .value (div_op1),
        .negate(div_sign & div_op1[WIDTH-1]),
        .result(op1_mag)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_abs_op2 (
        .value (div_op2),
        .negate(div_sign & div_op2[WIDTH-1]),
        .result(op2_mag)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
        .value (quo_next),
        .negate(q_neg),
        .result(q_fixed)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
        .value (rem_next),
        .negate(r_neg),
        .result(r_fixed)
    );

`ifdef SEQ_DIVIDER_EARLY_OUT_EN
    assign early = (op2_mag == '0) || (op1_mag < op2_mag);
`else
    assign early = 1'b0;
`endif

    // quo starts as the dividend magnitude and is shifted out MSB-first while quotient bits fill the LSB
    assign rem_wide = {rem, quo[WIDTH-1]};
    assign diff     = rem_wide - {1'b0, dvs};

    always_comb begin
        rem_next = diff[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], 1'b1};
        if (diff[WIDTH]) begin
            rem_next = rem_wide[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
        if (skip) begin
            rem_next = rem;
            quo_next = quo;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (div_begin) state_next = BUSY;
            BUSY: begin
                if (!div_begin)       state_next = IDLE;
                else if (cnt == '0)   state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt           <= '0;
            rem           <= '0;
            quo           <= '0;
            dvs           <= '0;
            q_neg         <= 1'b0;
            r_neg         <= 1'b0;
            skip          <= 1'b0;
            div_result    <= '0;
            div_remainder <= '0;
            div_end       <= 1'b0;
        end else begin
            div_end <= 1'b0;
            case (state)
                IDLE: if (div_begin) begin
                    q_neg <= (div_op1[WIDTH-1] ^ div_op2[WIDTH-1]) & div_sign;
                    r_neg <= div_op1[WIDTH-1] & div_sign;
                    dvs   <= op2_mag;
                    skip  <= early;
                    if (early) begin
                        // single pass-through BUSY cycle keeps div_end registered like the full path
                        rem <= op1_mag;
                        quo <= (op2_mag == '0) ? '1 : '0;
                        cnt <= '0;
                    end else begin
                        rem <= '0;
                        quo <= op1_mag;
                        cnt <= CNT_W'(WIDTH - 1);
                    end
                end
                BUSY: if (div_begin) begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == '0) begin
                        div_result    <= q_fixed;
                        div_remainder <= r_fixed;
                        div_end       <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: driver queues expected results, monitor checks on div_end.
module tb_seq_divider;

    localparam int WIDTH    = 32;
    localparam int LAT_FULL = WIDTH + 1;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        div_begin = 1'b0;
    logic        div_sign  = 1'b0;
    logic [31:0] div_op1   = '0;
    logic [31:0] div_op2   = '0;
    logic [31:0] div_result, div_remainder;
    logic        div_end;

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int end_count = 0;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          start;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb[$];

    seq_divider #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .div_begin    (div_begin),
        .div_sign     (div_sign),
        .div_op1      (div_op1),
        .div_op2      (div_op2),
        .div_result   (div_result),
        .div_remainder(div_remainder),
        .div_end      (div_end)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every div_end must match the oldest queued expectation
    initial begin
        logic prev_end;
        exp_t e;
        prev_end = 1'b0;
        forever begin
            @(negedge clk);
            if (div_end) begin
                end_count = end_count + 1;
                chk("end_pulse_prev_low", {31'b0, prev_end}, 32'd0);
                if (sb.size() == 0) begin
                    checks   = checks + 1;
                    failures = failures + 1;
                    $display("FAIL unexpected_end: q=%h r=%h with nothing expected", div_result, div_remainder);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_q"}, div_result, e.q);
                    chk({e.name, "_r"}, div_remainder, e.r);
                    chk({e.name, "_latency"}, 32'(cyc - e.start), 32'(e.lat));
                end
            end
            prev_end = div_end;
        end
    end

    task automatic push_exp(input string name, input logic [31:0] q, input logic [31:0] r,
                            input int start, input bit early);
        exp_t e;
        e.name  = name;
        e.q     = q;
        e.r     = r;
        e.start = start;
        e.lat   = (EARLY_OUT && early) ? 2 : LAT_FULL;
        sb.push_back(e);
    endtask

    task automatic issue(input string name, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [31:0] r, input bit early);
        @(negedge clk);
        div_sign  = s;
        div_op1   = a;
        div_op2   = b;
        div_begin = 1'b1;
        push_exp(name, q, r, cyc, early);
    endtask

    task automatic wait_end(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (div_end) begin
                seen = 1'b1;
                break;
            end
        end
        checks = checks + 1;
        if (!seen) begin
            failures = failures + 1;
            $display("FAIL %s_timeout: div_end not seen within 100 cycles", name);
        end
    endtask

    task automatic run_div(input string name, input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] q, input logic [31:0] r, input bit early);
        issue(name, s, a, b, q, r, early);
        wait_end(name);
        div_begin = 1'b0;
    endtask

    initial begin
        int saved_ends;
        int first_end;

        repeat (3) @(negedge clk);
        chk("reset_q", div_result, 32'h0);
        chk("reset_r", div_remainder, 32'h0);
        chk("reset_end", {31'b0, div_end}, 32'h0);
        reset = 1'b0;

        run_div("u100_7",    1'b0, 32'd100,       32'd7,         32'h0000000E, 32'h00000002, 1'b0);
        run_div("s_m7_2",    1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        run_div("s_7_m2",    1'b1, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0);
        run_div("s_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'h0000000E, 32'hFFFFFFFE, 1'b0);
        run_div("u_div0",    1'b0, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 32'h12345678, 1'b1);
        run_div("s_div0",    1'b1, 32'hFFFFFFFB, 32'h00000000, 32'h00000001, 32'hFFFFFFFB, 1'b1);
        run_div("s_ovf",     1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0);
        run_div("u_max_1",   1'b0, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0);
        run_div("u_3_10",    1'b0, 32'd3,         32'd10,        32'h00000000, 32'h00000003, 1'b1);

        // abort in the middle of BUSY: no completion, outputs keep the 3/10 result
        saved_ends = end_count;
        @(negedge clk);
        div_sign  = 1'b0;
        div_op1   = 32'd100;
        div_op2   = 32'd7;
        div_begin = 1'b1;
        repeat (10) @(negedge clk);
        div_begin = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_no_end", 32'(end_count), 32'(saved_ends));
        chk("abort_q_held", div_result, 32'h00000000);
        chk("abort_r_held", div_remainder, 32'h00000003);
        run_div("after_abort", 1'b0, 32'hFFFFFFF0, 32'd3, 32'h55555550, 32'h00000000, 1'b0);

        // reset mid-BUSY discards the operation and clears outputs
        issue("rst_mid", 1'b0, 32'd100, 32'd7, 32'h0000000E, 32'h00000002, 1'b0);
        repeat (6) @(negedge clk);
        reset     = 1'b1;
        div_begin = 1'b0;
        @(negedge clk);
        sb.delete();
        chk("rst_mid_q", div_result, 32'h0);
        chk("rst_mid_r", div_remainder, 32'h0);
        chk("rst_mid_end", {31'b0, div_end}, 32'h0);
        reset = 1'b0;
        run_div("after_rst", 1'b0, 32'd1000, 32'd10, 32'h00000064, 32'h00000000, 1'b0);

        // back-to-back with div_begin held through DONE; operand changes during BUSY ignored
        issue("b2b_1", 1'b0, 32'd100, 32'd7, 32'h0000000E, 32'h00000002, 1'b0);
        wait_end("b2b_1");
        first_end = cyc;
        div_op1 = 32'd1000;
        div_op2 = 32'd10;
        push_exp("b2b_2", 32'h00000064, 32'h00000000, cyc + 1, 1'b0);
        repeat (5) @(negedge clk);
        div_op1 = 32'h0000FFFF;
        div_op2 = 32'h00000001;
        wait_end("b2b_2");
        chk("b2b_gap", 32'(cyc - first_end), 32'(LAT_FULL + 1));
        div_begin = 1'b0;

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
